// File: rtl/apb_master_ctrl.sv
// APB requester: turns a valid/ready command stream into SETUP/ACCESS transfers, one response each.
// Optional ACCESS timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e state_q;
    logic   accept;
    logic   timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CntW-1:0] wait_cnt_q;

    // Fires on the ACCESS cycle that would be the TIMEOUT_CYCLES-th wait state
    assign timeout = (state_q == StAccess) && !PREADY &&
                     (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        cmd_ready = 1'b0;
        unique case (state_q)
            StIdle:   cmd_ready = PRESETn;
            StSetup:  cmd_ready = 1'b0;
            StAccess: cmd_ready = PREADY;
            default:  cmd_ready = 1'b0;
        endcase
    end

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= StIdle;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        PADDR   <= cmd_addr;
                        PWRITE  <= cmd_write;
                        PWDATA  <= cmd_wdata;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    PENABLE    <= 1'b1;
                    state_q    <= StAccess;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                StAccess: begin
                    if (PREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= PSLVERR;
                        rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
                        PENABLE   <= 1'b0;
                        if (accept) begin
                            // Chain straight into SETUP; PSEL stays high
                            PADDR   <= cmd_addr;
                            PWRITE  <= cmd_write;
                            PWDATA  <= cmd_wdata;
                            state_q <= StSetup;
                        end else begin
                            PSEL    <= 1'b0;
                            state_q <= StIdle;
                        end
                    end else if (timeout) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
`ifdef APB_MASTER_TIMEOUT_EN
                        wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed and random transfers against a latency/response model.
module tb_apb_master_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int errors = 0;
    int checks = 0;

    // Slave behaviour for the current transfer
    int unsigned slv_wait = 0;
    logic        slv_err  = 1'b0;
    logic [31:0] slv_rdata = '0;
    int unsigned acc_cnt;

    apb_master_ctrl #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    assign PREADY  = PSEL && PENABLE && (acc_cnt >= slv_wait);
    assign PSLVERR = slv_err;
    assign PRDATA  = slv_rdata;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) acc_cnt <= 0;
        else if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated transfer; response expected 3+wt negedges after the accept edge
    task automatic run_one(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input int unsigned wt, input logic er, input logic [31:0] rd);
        bit          seen;
        logic [31:0] exp_rd;
        exp_rd    = (!wr && !er) ? rd : 32'h0;
        slv_wait  = wt;
        slv_err   = er;
        slv_rdata = rd;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        #1 check("idle_ready", cmd_ready, 1);
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        seen = 0;
        for (int k = 1; k <= int'(wt) + 8 && !seen; k++) begin
            @(negedge PCLK);
            if (k == 1) begin
                check("setup_ctl", {PSEL, PENABLE}, 2'b10);
                check("setup_addr", PADDR, addr);
                check("setup_write", PWRITE, wr);
                check("setup_wdata", PWDATA, wd);
                check("setup_ready", cmd_ready, 0);
            end else if (rsp_valid) begin
                seen = 1;
                check("rsp_latency", k, wt + 3);
                check("rsp_err", rsp_err, er);
                check("rsp_rdata", rsp_rdata, exp_rd);
            end else begin
                check("access_ctl", {PSEL, PENABLE}, 2'b11);
                check("hold_addr", PADDR, addr);
                check("hold_write", PWRITE, wr);
            end
        end
        check("rsp_seen", seen, 1);
        @(negedge PCLK);
        check("rsp_one_cycle", rsp_valid, 0);
        check("back_idle", {PSEL, PENABLE}, 2'b00);
    endtask

    initial begin
        logic        acc;
        int          ci;
        int          ri;
        logic [31:0] bb_wd [4];
        logic [31:0] bb_rd;

        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        repeat (2) @(negedge PCLK);
        check("rst_apb", {PSEL, PENABLE, PWRITE}, 3'b000);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
        check("rst_rdata", rsp_rdata, 0);
        PRESETn = 1'b1;
        #1 check("rst_ready", cmd_ready, 1);

        // Zero-wait write, then a read with three wait states
        run_one(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, $urandom);
        run_one(1'b0, 32'h10, $urandom, 3, 1'b0, 32'hDEADBEEF);

        // Back-to-back: W/R/W/R at 0x0..0xC with cmd_valid held high
        bb_rd     = $urandom;
        slv_wait  = 0;
        slv_err   = 1'b0;
        slv_rdata = bb_rd;
        for (int i = 0; i < 4; i++) bb_wd[i] = $urandom;
        @(negedge PCLK);
        ci = 0;
        ri = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0;
        cmd_wdata = bb_wd[0];
        for (int k = 0; k <= 10; k++) begin
            #1 acc = cmd_valid && cmd_ready;
            if (k >= 1) begin
                check("b2b_psel", PSEL, (k <= 8) ? 1 : 0);
                if ((k % 2) == 1 && k <= 7) check("b2b_addr", PADDR, 32'((k - 1) * 2));
                check("b2b_rsp", rsp_valid, ((k % 2) == 1 && k >= 3 && k <= 9) ? 1 : 0);
                if (rsp_valid) begin
                    check("b2b_err", rsp_err, 0);
                    check("b2b_rdata", rsp_rdata, ((ri % 2) == 0) ? 32'h0 : bb_rd);
                    ri++;
                end
            end
            @(posedge PCLK);
            #1;
            if (acc) begin
                ci++;
                if (ci < 4) begin
                    cmd_write = ((ci % 2) == 0);
                    cmd_addr  = 32'(ci * 4);
                    cmd_wdata = bb_wd[ci];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            @(negedge PCLK);
        end
        check("b2b_accepted", ci, 4);
        check("b2b_responses", ri, 4);

        // Slave error on a read masks PRDATA
        run_one(1'b0, $urandom, $urandom, 0, 1'b1, 32'h1234);

        for (int i = 0; i < 6; i++) begin
            run_one(1'($urandom), $urandom, $urandom, $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0), $urandom);
        end

        // Reset during a stalled write ACCESS
        slv_wait = 1000;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'hA5A0;
        cmd_wdata = $urandom;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge PCLK);
        check("pre_rst_access", {PSEL, PENABLE}, 2'b11);
        #2 PRESETn = 1'b0;
        #1;
        check("midrst_apb", {PSEL, PENABLE, PWRITE, cmd_ready}, 4'b0000);
        check("midrst_paddr", PADDR, 0);
        check("midrst_pwdata", PWDATA, 0);
        check("midrst_rsp", {rsp_valid, rsp_err}, 2'b00);
        check("midrst_rdata", rsp_rdata, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge PCLK);
            check("midrst_no_rsp", rsp_valid, 0);
        end
        PRESETn  = 1'b1;
        slv_wait = 0;
        run_one(1'b0, 32'h44, $urandom, 1, 1'b0, $urandom);

`ifdef APB_MASTER_TIMEOUT_EN
        // Stuck slave: terminates after 4 ACCESS cycles, refuses a command on that edge
        slv_wait = 1000;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h80;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge PCLK);
            if (k == 5) cmd_valid = 1'b1;
            #1;
            if (k >= 2 && k <= 5) begin
                check("to_access", {PSEL, PENABLE}, 2'b11);
                check("to_no_rsp", rsp_valid, 0);
            end
            if (k == 5) check("to_ready", cmd_ready, 0);
            if (k == 6) begin
                check("to_rsp", {rsp_valid, rsp_err}, 2'b11);
                check("to_rdata", rsp_rdata, 0);
                check("to_idle", {PSEL, PENABLE}, 2'b00);
                check("to_idle_ready", cmd_ready, 1);
                cmd_valid = 1'b0;
            end
        end
        slv_wait = 0;
        run_one(1'b1, 32'h84, $urandom, 0, 1'b0, $urandom);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
